// File: rtl/uart_cfg_if.sv
// Handshake and line signals between a UART user and uart_cfg.
// master = user/driver side, slave = the UART itself.
interface uart_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_parity_err;
  logic                 rx_frame_err;

  modport master (
    output tx_start, tx_data, rx,
    input  tx, tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );

  modport slave (
    input  tx_start, tx_data, rx,
    output tx, tx_busy, tx_done, rx_data, rx_valid, rx_parity_err, rx_frame_err
  );
endinterface

// File: rtl/uart_cfg.sv
// Parameterised UART: independent TX/RX FSMs. TX line low 1 cycle after an accepted tx_start;
// rx results 1 cycle after the last stop sample. No queuing: tx_start while busy is dropped.
module uart_cfg #(
  parameter int CLK_FREQ  = 100_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input logic       clk,
  input logic       rst,
  uart_cfg_if.slave bus
);
  localparam int             BIT_CYC   = CLK_FREQ / BAUD;
  localparam int             BW        = $clog2(BIT_CYC);
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BIT_CYC - 1);
  localparam logic [BW-1:0]  HALF_LAST = BW'(BIT_CYC / 2 - 1);
  localparam logic [BW-1:0]  BAUD_ONE  = BW'(1);
  localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic           PAR_EN    = (PARITY != 0);
  localparam logic           PAR_ODD   = (PARITY == 1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state, tx_state_n;
  logic [BW-1:0]        tx_baud, tx_baud_n;
  logic [3:0]           tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0] tx_shr, tx_shr_n;
  logic                 tx_par, tx_par_n;
  logic                 tx_line, tx_line_n;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shr   <= tx_shr_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_bit_end ? '0 : tx_baud + BAUD_ONE;
    tx_bit_n   = tx_bit;
    tx_shr_n   = tx_shr;
    tx_par_n   = tx_par;
    tx_line_n  = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_baud_n = '0;
        if (bus.tx_start) begin
          tx_state_n = TX_START;
          tx_shr_n   = bus.tx_data;
          tx_par_n   = (^bus.tx_data) ^ PAR_ODD;
        end
      end
      TX_START: if (tx_bit_end) begin
        tx_state_n = TX_DATA;
        tx_bit_n   = '0;
      end
      TX_DATA: if (tx_bit_end) begin
        tx_shr_n = tx_shr >> 1;
        if (tx_bit == DATA_LAST) begin
          tx_bit_n   = '0;
          tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
        end else begin
          tx_bit_n = tx_bit + 4'd1;
        end
      end
      TX_PARITY: if (tx_bit_end) begin
        tx_state_n = TX_STOP;
        tx_bit_n   = '0;
      end
      TX_STOP: if (tx_bit_end) begin
        if (tx_bit == STOP_LAST) tx_state_n = TX_IDLE;
        else                     tx_bit_n   = tx_bit + 4'd1;
      end
      default: tx_state_n = TX_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (tx_state_n)
      TX_START:  tx_line_n = 1'b0;
      TX_DATA:   tx_line_n = tx_shr_n[0];
      TX_PARITY: tx_line_n = tx_par_n;
      default:   tx_line_n = 1'b1;
    endcase
  end

  assign bus.tx      = tx_line;
  assign bus.tx_busy = (tx_state != TX_IDLE);
  assign bus.tx_done = (tx_state == TX_STOP) && tx_bit_end && (tx_bit == STOP_LAST);

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  rx_state_t            rx_state, rx_state_n;
  logic [BW-1:0]        rx_baud, rx_baud_n;
  logic [3:0]           rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0] rx_shr, rx_shr_n;
  logic                 rx_par, rx_par_n;
  logic                 rx_ferr, rx_ferr_n;
  logic                 rx_s1, rx_sync;
  logic                 rx_bit_end, rx_fin;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_perr_q, rx_ferr_q;

  assign rx_bit_end = (rx_baud == BAUD_LAST);
  assign rx_fin     = (rx_state == RX_STOP) && rx_bit_end && (rx_bit == STOP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_s1   <= bus.rx;
      rx_sync <= rx_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shr   <= '0;
      rx_par   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shr   <= rx_shr_n;
      rx_par   <= rx_par_n;
      rx_ferr  <= rx_ferr_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_baud_n  = rx_bit_end ? '0 : rx_baud + BAUD_ONE;
    rx_bit_n   = rx_bit;
    rx_shr_n   = rx_shr;
    rx_par_n   = rx_par;
    rx_ferr_n  = rx_ferr;
    case (rx_state)
      RX_IDLE: begin
        rx_baud_n = '0;
        if (!rx_sync) rx_state_n = RX_START;
      end
      RX_START: begin
        // Half-bit check rejects short low glitches on an idle line.
        if (rx_baud == HALF_LAST) begin
          rx_baud_n = '0;
          if (rx_sync) begin
            rx_state_n = RX_IDLE;
          end else begin
            rx_state_n = RX_DATA;
            rx_bit_n   = '0;
            rx_ferr_n  = 1'b0;
          end
        end else begin
          rx_baud_n = rx_baud + BAUD_ONE;
        end
      end
      RX_DATA: if (rx_bit_end) begin
        rx_shr_n = {rx_sync, rx_shr[DATA_BITS-1:1]};
        if (rx_bit == DATA_LAST) begin
          rx_bit_n   = '0;
          rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
        end else begin
          rx_bit_n = rx_bit + 4'd1;
        end
      end
      RX_PARITY: if (rx_bit_end) begin
        rx_par_n   = rx_sync;
        rx_bit_n   = '0;
        rx_state_n = RX_STOP;
      end
      RX_STOP: if (rx_bit_end) begin
        if (!rx_sync) rx_ferr_n = 1'b1;
        if (rx_bit == STOP_LAST) rx_state_n = (rx_ferr || !rx_sync) ? RX_WAIT_HIGH : RX_IDLE;
        else                     rx_bit_n   = rx_bit + 4'd1;
      end
      RX_WAIT_HIGH: begin
        rx_baud_n = '0;
        if (rx_sync) rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= rx_fin;
      if (rx_fin) begin
        rx_data_q <= rx_shr;
        rx_perr_q <= PAR_EN && (rx_par != ((^rx_shr) ^ PAR_ODD));
        rx_ferr_q <= rx_ferr | ~rx_sync;
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: four instances (8N1, 8E1, 8O1, 8N2 in loopback) with queue-based scoreboards.
module tb_uart_cfg;
  localparam int BC = 10;
  localparam int N1 = 0, E1 = 1, O1 = 2, N2 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_cfg_if #(.DATA_BITS(8)) if_n1 ();
  uart_cfg_if #(.DATA_BITS(8)) if_e1 ();
  uart_cfg_if #(.DATA_BITS(8)) if_o1 ();
  uart_cfg_if #(.DATA_BITS(8)) if_n2 ();

  uart_cfg #(.PARITY(0), .STOP_BITS(1)) u_n1 (.clk(clk), .rst(rst), .bus(if_n1));
  uart_cfg #(.PARITY(2), .STOP_BITS(1)) u_e1 (.clk(clk), .rst(rst), .bus(if_e1));
  uart_cfg #(.PARITY(1), .STOP_BITS(1)) u_o1 (.clk(clk), .rst(rst), .bus(if_o1));
  uart_cfg #(.PARITY(0), .STOP_BITS(2)) u_n2 (.clk(clk), .rst(rst), .bus(if_n2));

  assign if_n2.rx = if_n2.tx;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } rx_exp_t;

  rx_exp_t rx_q[$];
  logic    tx_q[$];
  int      n_cmp = 0;
  int      n_bad = 0;
  int      tsel = N1;
  int      rsel = N1;

  logic       m_tx, m_busy, m_done;
  logic [7:0] m_rdata;
  logic       m_rvalid, m_perr, m_ferr;

  always_comb begin
    m_tx = if_n1.tx; m_busy = if_n1.tx_busy; m_done = if_n1.tx_done;
    if (tsel == E1)      begin m_tx = if_e1.tx; m_busy = if_e1.tx_busy; m_done = if_e1.tx_done; end
    else if (tsel == O1) begin m_tx = if_o1.tx; m_busy = if_o1.tx_busy; m_done = if_o1.tx_done; end
    else if (tsel == N2) begin m_tx = if_n2.tx; m_busy = if_n2.tx_busy; m_done = if_n2.tx_done; end
  end

  always_comb begin
    m_rdata = if_n1.rx_data; m_rvalid = if_n1.rx_valid; m_perr = if_n1.rx_parity_err; m_ferr = if_n1.rx_frame_err;
    if (rsel == E1) begin
      m_rdata = if_e1.rx_data; m_rvalid = if_e1.rx_valid; m_perr = if_e1.rx_parity_err; m_ferr = if_e1.rx_frame_err;
    end else if (rsel == N2) begin
      m_rdata = if_n2.rx_data; m_rvalid = if_n2.rx_valid; m_perr = if_n2.rx_parity_err; m_ferr = if_n2.rx_frame_err;
    end
  end

  task automatic set_start(input int sel, input logic v, input logic [7:0] d);
    if (sel == N1)      begin if_n1.tx_start = v; if_n1.tx_data = d; end
    else if (sel == E1) begin if_e1.tx_start = v; if_e1.tx_data = d; end
    else if (sel == O1) begin if_o1.tx_start = v; if_o1.tx_data = d; end
    else                begin if_n2.tx_start = v; if_n2.tx_data = d; end
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == N1) if_n1.rx = v;
    else           if_e1.rx = v;
  endtask

  task automatic push_rx(input logic [7:0] d, input logic p, input logic f);
    rx_exp_t e;
    e.data = d; e.perr = p; e.ferr = f;
    rx_q.push_back(e);
  endtask

  // Drives one frame on rx, bit-banged at BC cycles per bit; called at a negedge.
  task automatic drive_frame(input int sel, input logic [7:0] d, input int par,
                             input logic flip, input logic stop_val);
    set_rx(sel, 1'b0);
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      repeat (BC) @(negedge clk);
    end
    if (par != 0) begin
      set_rx(sel, (^d) ^ (par == 1) ^ flip);
      repeat (BC) @(negedge clk);
    end
    set_rx(sel, stop_val);
    repeat (BC) @(negedge clk);
  endtask

  // Sends one word and checks the line, busy and done every cycle; called at a negedge.
  task automatic tx_frame(input int sel, input logic [7:0] d, input int par, input int nstop,
                          input int poke, input string name);
    int   total;
    logic exp_b;
    tsel = sel;
    exp_b = 1'b1;
    tx_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) tx_q.push_back(d[i]);
    if (par != 0) tx_q.push_back((^d) ^ (par == 1));
    for (int i = 0; i < nstop; i++) tx_q.push_back(1'b1);
    total = BC * (1 + 8 + ((par != 0) ? 1 : 0) + nstop);
    set_start(sel, 1'b1, d);
    @(negedge clk);
    set_start(sel, 1'b0, d);
    for (int c = 1; c <= total; c++) begin
      if ((c - 1) % BC == 0) exp_b = tx_q.pop_front();
      if (c == poke)     set_start(sel, 1'b1, ~d);
      if (c == poke + 1) set_start(sel, 1'b0, d);
      n_cmp++;
      if (m_tx !== exp_b) begin
        n_bad++; $display("FAIL %s tx cyc %0d: got %b want %b", name, c, m_tx, exp_b);
      end
      n_cmp++;
      if (m_busy !== 1'b1) begin
        n_bad++; $display("FAIL %s tx_busy cyc %0d: got %b want 1", name, c, m_busy);
      end
      n_cmp++;
      if (m_done !== (c == total)) begin
        n_bad++; $display("FAIL %s tx_done cyc %0d: got %b want %b", name, c, m_done, (c == total));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (m_busy !== 1'b0 || m_tx !== 1'b1 || m_done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle after frame: busy/tx/done got %b%b%b want 010", name, m_busy, m_tx, m_done);
    end
  endtask

  task automatic expect_rx(input string name, input int budget);
    rx_exp_t e;
    int      w;
    w = 0;
    while (m_rvalid !== 1'b1 && w < budget) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (m_rvalid !== 1'b1) begin
      n_bad++; $display("FAIL %s rx_valid: got timeout after %0d cycles want pulse", name, budget);
      if (rx_q.size() > 0) void'(rx_q.pop_front());
      return;
    end
    e = rx_q.pop_front();
    n_cmp++;
    if (m_rdata !== e.data) begin
      n_bad++; $display("FAIL %s rx_data: got %h want %h", name, m_rdata, e.data);
    end
    n_cmp++;
    if (m_perr !== e.perr) begin
      n_bad++; $display("FAIL %s rx_parity_err: got %b want %b", name, m_perr, e.perr);
    end
    n_cmp++;
    if (m_ferr !== e.ferr) begin
      n_bad++; $display("FAIL %s rx_frame_err: got %b want %b", name, m_ferr, e.ferr);
    end
    @(negedge clk);
    n_cmp++;
    if (m_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL %s rx_valid width: got %b want 0 one cycle later", name, m_rvalid);
    end
  endtask

  task automatic test_reset;
    tsel = N1; rsel = N1;
    rst = 1'b1;
    #3;
    n_cmp++; if (m_tx !== 1'b1)       begin n_bad++; $display("FAIL reset tx: got %b want 1", m_tx); end
    n_cmp++; if (m_busy !== 1'b0)     begin n_bad++; $display("FAIL reset tx_busy: got %b want 0", m_busy); end
    n_cmp++; if (m_done !== 1'b0)     begin n_bad++; $display("FAIL reset tx_done: got %b want 0", m_done); end
    n_cmp++; if (m_rvalid !== 1'b0)   begin n_bad++; $display("FAIL reset rx_valid: got %b want 0", m_rvalid); end
    n_cmp++; if (m_rdata !== 8'h00)   begin n_bad++; $display("FAIL reset rx_data: got %h want 00", m_rdata); end
    n_cmp++; if (m_perr !== 1'b0 || m_ferr !== 1'b0) begin
      n_bad++; $display("FAIL reset err flags: got %b%b want 00", m_perr, m_ferr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_tx_8n1;
    tx_frame(N1, 8'hA5, 0, 1, 0, "8n1_a5");
  endtask

  task automatic test_tx_parity;
    @(negedge clk);
    tx_frame(E1, 8'h07, 2, 1, 0, "8e1_07");
    @(negedge clk);
    tx_frame(O1, 8'h07, 1, 1, 0, "8o1_07");
  endtask

  task automatic test_busy_ignore;
    int seen;
    @(negedge clk);
    tx_frame(N1, 8'h3A, 0, 1, 30, "busy_ignore");
    seen = 0;
    repeat (30) begin
      if (m_busy !== 1'b0 || m_tx !== 1'b1) seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL busy_ignore queued frame: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    tx_frame(N1, 8'h81, 0, 1, 0, "b2b_first");
    tx_frame(N1, 8'h7E, 0, 1, 0, "b2b_second");
  endtask

  task automatic test_loopback;
    rsel = N2;
    @(negedge clk);
    push_rx(8'h3C, 1'b0, 1'b0);
    push_rx(8'hC3, 1'b0, 1'b0);
    fork
      begin
        tx_frame(N2, 8'h3C, 0, 2, 0, "lb_tx1");
        tx_frame(N2, 8'hC3, 0, 2, 0, "lb_tx2");
      end
      begin
        expect_rx("lb_rx1", 300);
        expect_rx("lb_rx2", 300);
      end
    join
  endtask

  task automatic test_rx_errors;
    int seen;
    rsel = E1;
    @(negedge clk);
    push_rx(8'h55, 1'b1, 1'b0);
    fork
      drive_frame(E1, 8'h55, 2, 1'b1, 1'b1);
      expect_rx("rx_par_err", 200);
    join
    repeat (5) @(negedge clk);
    push_rx(8'hA3, 1'b0, 1'b1);
    fork
      drive_frame(E1, 8'hA3, 2, 1'b0, 1'b0);
      expect_rx("rx_frm_err", 200);
    join
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rx_break rx_valid while low: got %0d want 0", seen); end
    set_rx(E1, 1'b1);
    repeat (20) @(negedge clk);
    push_rx(8'h3C, 1'b0, 1'b0);
    fork
      drive_frame(E1, 8'h3C, 2, 1'b0, 1'b1);
      expect_rx("rx_after_break", 200);
    join
  endtask

  task automatic test_glitch;
    int seen;
    rsel = N1;
    @(negedge clk);
    set_rx(N1, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(N1, 1'b1);
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rx_glitch rx_valid: got %0d want 0", seen); end
    push_rx(8'h96, 1'b0, 1'b0);
    fork
      drive_frame(N1, 8'h96, 0, 1'b0, 1'b1);
      expect_rx("rx_post_glitch", 200);
    join
  endtask

  task automatic test_reset_midframe;
    int seen;
    tsel = N1;
    @(negedge clk);
    set_start(N1, 1'b1, 8'hA5);
    set_rx(N1, 1'b0);
    @(negedge clk);
    set_start(N1, 1'b0, 8'hA5);
    repeat (44) @(negedge clk);
    n_cmp++;
    if (m_tx !== 1'b0) begin n_bad++; $display("FAIL midframe tx at cyc 45: got %b want 0", m_tx); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (m_tx !== 1'b1) begin n_bad++; $display("FAIL midframe async tx: got %b want 1", m_tx); end
    n_cmp++;
    if (m_busy !== 1'b0) begin n_bad++; $display("FAIL midframe async tx_busy: got %b want 0", m_busy); end
    n_cmp++;
    if (if_e1.rx_data !== 8'h00) begin n_bad++; $display("FAIL midframe async rx_data: got %h want 00", if_e1.rx_data); end
    set_rx(N1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (150) begin
      @(negedge clk);
      if (if_n1.tx_done === 1'b1 || if_n1.rx_valid === 1'b1 || if_n1.tx_busy === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL midframe stray activity: got %0d cycles want 0", seen); end
    tx_frame(N1, 8'hA5, 0, 1, 0, "post_reset");
  endtask

  initial begin
    if_n1.tx_start = 1'b0; if_n1.tx_data = '0; if_n1.rx = 1'b1;
    if_e1.tx_start = 1'b0; if_e1.tx_data = '0; if_e1.rx = 1'b1;
    if_o1.tx_start = 1'b0; if_o1.tx_data = '0; if_o1.rx = 1'b1;
    if_n2.tx_start = 1'b0; if_n2.tx_data = '0;
    test_reset();
    test_tx_8n1();
    test_tx_parity();
    test_busy_ignore();
    test_back_to_back();
    test_loopback();
    test_rx_errors();
    test_glitch();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got no completion by 500000 time units want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 100_000; input clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600; line bit rate; BIT_CYC = CLK_FREQ/BAUD (integer truncation, must be >= 4).
REQ-003 Parameter DATA_BITS, default 8; legal 5..9.
REQ-004 Parameter PARITY, default 0; 0 = none, 1 = odd, 2 = even.
REQ-005 Parameter STOP_BITS, default 1; legal 1 or 2.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 tx_start  in  1  request to send tx_data; sampled only in TX IDLE.
REQ-009 tx_data  in  DATA_BITS  transmit word; captured on accepted tx_start.
REQ-010 tx  out  1  serial line out, idle high.
REQ-011 tx_busy  out  1  high from the cycle after acceptance until TX returns to IDLE.
REQ-012 tx_done  out  1  one-cycle pulse at end of last stop bit.
REQ-013 rx  in  1  asynchronous serial line in.
REQ-014 rx_data  out  DATA_BITS  last received word; held until next rx_valid.
REQ-015 rx_valid  out  1  one-cycle pulse, frame received.
REQ-016 rx_parity_err  out  1  qualified by rx_valid; parity mismatch.
REQ-017 rx_frame_err  out  1  qualified by rx_valid; a sampled stop bit was 0.

Function
REQ-018 TX FSM states: IDLE, START, DATA, PARITY, STOP; PARITY state skipped when PARITY = 0.
REQ-019 In IDLE with tx_start = 1, the block shall latch tx_data, and tx shall go low on the next cycle (1-cycle latency).
REQ-020 Each bit shall be held for exactly BIT_CYC cycles; data shall be sent LSB first.
REQ-021 Parity bit: even -> XOR of data bits; odd -> inverted XOR.
REQ-022 Frame length shall be BIT_CYC*(1+DATA_BITS+(PARITY!=0)+STOP_BITS) cycles; tx_done pulses in the last cycle of the frame, and TX is in IDLE the following cycle.
REQ-023 tx_start while tx_busy shall be ignored (no queuing); tx_start in the cycle after tx_done shall be accepted (back-to-back frames, no idle gap).
REQ-024 The bit counter and baud counter shall be reset at every state entry; there shall be no free-running shared tick.
REQ-025 rx shall pass through a 2-flop synchronizer; all RX decisions use the synchronized value.
REQ-026 RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-027 IDLE -> START on synchronized rx = 0; START shall resample at BIT_CYC/2 cycles; if high, treat as a glitch and return to IDLE with no outputs.
REQ-028 Following samples shall be taken every BIT_CYC cycles (mid-bit) for data, parity, and each of the STOP_BITS stop bits.
REQ-029 rx_valid, rx_data, rx_parity_err, and rx_frame_err shall update in the cycle after the final stop-bit sample.
REQ-030 A frame error shall still assert rx_valid; RX then enters WAIT_HIGH and re-arms only after synchronized rx = 1 (break handling).
REQ-031 TX and RX are fully independent; simultaneous TX and RX activity shall be supported.

Reset
REQ-032 On rst, outputs shall go to tx = 1, tx_busy = 0, tx_done = 0, rx_valid = 0, rx_data = 0, both error flags = 0, immediately (asynchronously).
REQ-033 Reset mid-frame shall abort both FSMs to IDLE, clear counters and synchronizer flops to 1, and generate no tx_done or rx_valid.

Verification (defaults, BIT_CYC = 10)
REQ-034 8N1: tx_start with tx_data = 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles; tx_done at cycle 100 after acceptance; tx_busy high for cycles 1..100.
REQ-035 8E1: tx_data = 0x07 -> parity bit 1, frame 110 cycles; 8O1 with the same data -> parity bit 0.
REQ-036 Loopback tx to rx, 8N2, send 0x3C then 0xC3 back-to-back -> two rx_valid pulses with rx_data = 0x3C then 0xC3, no errors.
REQ-037 rx driven with 0x55 frame in 8E1 with the parity bit flipped -> rx_valid with rx_data = 0x55 and rx_parity_err = 1; a stop bit forced to 0 -> rx_frame_err = 1, and no new frame is accepted until rx returns high.
REQ-038 rx low for 3 cycles, then high -> no rx_valid; a subsequent valid frame is received correctly.
REQ-039 rst asserted at cycle 45 of a TX frame -> tx = 1 in the same cycle; a new tx_start after rst release produces a complete, correct frame.
